// File: rtl/fft_ctrl_pkg.sv
// Shared types, default widths and the transform-length legality check for the FFT frame controller.
package fft_ctrl_pkg;

    localparam int DATA_W_DEF  = 18;
    localparam int PTS_W_DEF   = 11;
    localparam int MIN_PTS_DEF = 64;
    localparam int MAX_PTS_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        ERR    = 3'd4
    } state_t;

    // Legal lengths are powers of two inside [min_pts, max_pts].
    function automatic logic pts_legal(input int unsigned pts,
                                       input int unsigned min_pts,
                                       input int unsigned max_pts);
        return (pts != 0) && ((pts & (pts - 1)) == 0) &&
               (pts >= min_pts) && (pts <= max_pts);
    endfunction

endpackage

// File: rtl/fft_beat_counter.sv
// Beat counter with synchronous clear (priority over increment) and zero/last-beat compares.
// Compares are combinational on the registered count; no flow control of its own.
module fft_beat_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         is_zero,
    output logic         is_last
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + W'(1);
        end
    end

    assign is_zero = (cnt == '0);
    assign is_last = (cnt == last);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames a sample stream into an FFT core and checks the core's output framing; zero-latency data path.
// Input backpressure passes straight through from sink_ready, output backpressure from out_ready.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PTS_W   = PTS_W_DEF,
    parameter int MIN_PTS = MIN_PTS_DEF,
    parameter int MAX_PTS = MAX_PTS_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_start,
    input  logic [PTS_W-1:0]  cfg_pts,
    input  logic              cfg_inverse,
    input  logic              abort,
    input  logic              err_clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    output logic              sink_valid,
    input  logic              sink_ready,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [DATA_W-1:0] sink_real,
    output logic [DATA_W-1:0] sink_imag,
    output logic [1:0]        sink_error,
    output logic [PTS_W-1:0]  fftpts_in,
    output logic              inverse,
    input  logic              source_valid,
    input  logic              source_sop,
    input  logic              source_eop,
    input  logic [1:0]        source_error,
    output logic              source_ready,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       frame_cnt
);

    state_t             state;
    logic               in_fire, src_fire, src_bad, active;
    logic               in_clr, out_clr;
    logic               in_zero, in_last, out_zero, out_last;
    logic [PTS_W-1:0]   pts_last, in_cnt, out_cnt;

    assign active       = (state == STREAM) || (state == DRAIN);
    assign sink_valid   = (state == STREAM) && in_valid;
    assign in_ready     = (state == STREAM) && sink_ready;
    assign source_ready = active && out_ready;
    assign sink_real    = in_real;
    assign sink_imag    = in_imag;
    assign sink_error   = 2'b00;
    assign sink_sop     = sink_valid && in_zero;
    assign sink_eop     = sink_valid && in_last;
    assign busy         = (state == LOAD) || active;
    assign err          = (state == ERR);

    assign in_fire  = sink_valid && sink_ready;
    assign src_fire = source_valid && source_ready;
    assign pts_last = fftpts_in - PTS_W'(1);

    // Any error code or a sop/eop landing on the wrong beat is a framing fault.
    assign src_bad = (source_error != 2'b00) ||
                     (source_sop && !out_zero) ||
                     (source_eop && !out_last);

    assign in_clr  = (state != STREAM) || abort || (in_fire && in_last);
    assign out_clr = !active || abort;

    fft_beat_counter #(.W(PTS_W)) u_in_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (in_clr),
        .inc     (in_fire),
        .last    (pts_last),
        .cnt     (in_cnt),
        .is_zero (in_zero),
        .is_last (in_last)
    );

    fft_beat_counter #(.W(PTS_W)) u_out_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (out_clr),
        .inc     (src_fire),
        .last    (pts_last),
        .cnt     (out_cnt),
        .is_zero (out_zero),
        .is_last (out_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            fftpts_in <= PTS_W'(MAX_PTS);
            inverse   <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        if (pts_legal(32'(cfg_pts), MIN_PTS, MAX_PTS)) begin
                            state     <= LOAD;
                            fftpts_in <= cfg_pts;
                            inverse   <= cfg_inverse;
                        end else begin
                            state <= ERR;
                        end
                    end
                end
                LOAD: begin
                    state <= abort ? IDLE : STREAM;
                end
                STREAM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (src_fire && src_bad) begin
                        state <= ERR;
                    end else if (in_fire && in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (src_fire && src_bad) begin
                        state <= ERR;
                    end else if (src_fire && source_eop) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                ERR: begin
                    if (err_clear) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{in_cnt, out_cnt};

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: framing, illegal lengths, backpressure, abort, core errors, reset.
module tb_fft_frame_ctrl;

    localparam int DW = 18;
    localparam int PW = 11;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_start, cfg_inverse, abort, err_clear;
    logic [PW-1:0] cfg_pts;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_real, in_imag;
    logic          sink_valid, sink_ready, sink_sop, sink_eop;
    logic [DW-1:0] sink_real, sink_imag;
    logic [1:0]    sink_error;
    logic [PW-1:0] fftpts_in;
    logic          inverse;
    logic          source_valid, source_sop, source_eop, source_ready;
    logic [1:0]    source_error;
    logic          out_ready, busy, done, err;
    logic [15:0]   frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_start    (cfg_start),
        .cfg_pts      (cfg_pts),
        .cfg_inverse  (cfg_inverse),
        .abort        (abort),
        .err_clear    (err_clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_real      (in_real),
        .in_imag      (in_imag),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .sink_error   (sink_error),
        .fftpts_in    (fftpts_in),
        .inverse      (inverse),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_error (source_error),
        .source_ready (source_ready),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .frame_cnt    (frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int pts, input logic inv);
        cfg_pts     = PW'(pts);
        cfg_inverse = inv;
        cfg_start   = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    // Feeds an incrementing sample index; records where sop/eop were seen on transferred beats.
    task automatic stream(input int n, input int stop_after, input bit toggle,
                          output int xf, output int sop_at, output int eop_at, output int bad);
        xf = 0; sop_at = -1; eop_at = -1; bad = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 4 * n + 8; c++) begin
            sink_ready = toggle ? (c % 2 == 1) : 1'b1;
            in_real    = DW'(xf);
            in_imag    = DW'(xf + 5000);
            #1;
            if (sink_valid && sink_ready) begin
                if (sink_sop) begin
                    if (sop_at < 0) sop_at = xf;
                    else bad++;
                end
                if (sink_eop) eop_at = xf;
                if (sink_real !== DW'(xf) || sink_imag !== DW'(xf + 5000)) bad++;
                xf++;
            end
            step();
            if (eop_at >= 0 || xf == stop_after) break;
        end
        in_valid   = 1'b0;
        sink_ready = 1'b1;
    endtask

    // Plays the core's output side: n beats, optional error code on one beat.
    task automatic drain(input int n, input int err_beat, output int dones, output int beats);
        dones = 0; beats = 0;
        out_ready = 1'b1;
        for (int j = 0; j < n; j++) begin
            source_valid = 1'b1;
            source_sop   = (j == 0);
            source_eop   = (j == n - 1);
            source_error = (j == err_beat) ? 2'b01 : 2'b00;
            step();
            beats++;
            if (done) dones++;
            if (err) break;
        end
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'b00;
    endtask

    initial begin
        int xf, sop_at, eop_at, bad, dones, beats;
        reset_n = 1'b0;
        cfg_start = 1'b0; cfg_pts = '0; cfg_inverse = 1'b0; abort = 1'b0; err_clear = 1'b0;
        in_valid = 1'b0; in_real = '0; in_imag = '0; sink_ready = 1'b1;
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; source_error = 2'b00;
        out_ready = 1'b1;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fftpts", 32'(fftpts_in), 1024);
        chk("rst_inverse", 32'(inverse), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_source_ready", 32'(source_ready), 0);
        #2 reset_n = 1'b1;
        step();

        // 64-point frame, continuous input, echoing core
        start(64, 1'b1);
        chk("load_busy", 32'(busy), 1);
        chk("load_fftpts", 32'(fftpts_in), 64);
        chk("load_inverse", 32'(inverse), 1);
        in_valid = 1'b1;
        #1;
        chk("load_no_sink_valid", 32'(sink_valid), 0);
        chk("load_no_in_ready", 32'(in_ready), 0);
        chk("sink_error_zero", 32'(sink_error), 0);
        stream(64, -1, 1'b0, xf, sop_at, eop_at, bad);
        chk("f64_xfers", 32'(xf), 64);
        chk("f64_sop_at", 32'(sop_at), 0);
        chk("f64_eop_at", 32'(eop_at), 63);
        chk("f64_bad", 32'(bad), 0);
        in_valid = 1'b1;
        #1;
        chk("drain_no_sink_valid", 32'(sink_valid), 0);
        chk("drain_busy", 32'(busy), 1);
        in_valid = 1'b0;
        drain(64, -1, dones, beats);
        chk("f64_done_pulses", 32'(dones), 1);
        chk("f64_frame_cnt", 32'(frame_cnt), 1);
        chk("f64_idle_busy", 32'(busy), 0);
        step();
        chk("f64_done_one_cycle", 32'(done), 0);

        // illegal length 100 -> ERR, cfg_start ignored there, err_clear recovers
        start(100, 1'b0);
        chk("ill100_err", 32'(err), 1);
        chk("ill100_busy", 32'(busy), 0);
        chk("ill100_fftpts_held", 32'(fftpts_in), 64);
        in_valid = 1'b1;
        #1;
        chk("ill100_no_sink_valid", 32'(sink_valid), 0);
        in_valid = 1'b0;
        start(128, 1'b0);
        chk("err_ignores_start", 32'(err), 1);
        chk("err_ignores_start_busy", 32'(busy), 0);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("err_clear_err", 32'(err), 0);

        // boundary lengths: below min, above max, exact max then abort in LOAD
        start(32, 1'b0);
        chk("ill32_err", 32'(err), 1);
        err_clear = 1'b1; step(); err_clear = 1'b0;
        start(2048, 1'b0);
        chk("ill2048_err", 32'(err), 1);
        err_clear = 1'b1; step(); err_clear = 1'b0;
        start(1024, 1'b0);
        chk("max_legal_busy", 32'(busy), 1);
        chk("max_legal_fftpts", 32'(fftpts_in), 1024);
        abort = 1'b1; step(); abort = 1'b0;
        chk("abort_load_busy", 32'(busy), 0);

        // 256-point frame with sink_ready toggling
        start(256, 1'b0);
        stream(256, -1, 1'b1, xf, sop_at, eop_at, bad);
        chk("f256_xfers", 32'(xf), 256);
        chk("f256_sop_at", 32'(sop_at), 0);
        chk("f256_eop_at", 32'(eop_at), 255);
        chk("f256_bad", 32'(bad), 0);
        drain(256, -1, dones, beats);
        chk("f256_done_pulses", 32'(dones), 1);
        chk("f256_frame_cnt", 32'(frame_cnt), 2);

        // abort after 30 beats of a 128-point frame
        start(128, 1'b0);
        stream(128, 30, 1'b0, xf, sop_at, eop_at, bad);
        chk("abort_xfers_before", 32'(xf), 30);
        abort = 1'b1; in_valid = 1'b1;
        step();
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_no_done", 32'(done), 0);
        chk("abort_frame_cnt", 32'(frame_cnt), 2);
        start(64, 1'b0);
        stream(64, -1, 1'b0, xf, sop_at, eop_at, bad);
        chk("post_abort_sop_at", 32'(sop_at), 0);
        chk("post_abort_eop_at", 32'(eop_at), 63);
        drain(64, -1, dones, beats);
        chk("post_abort_frame_cnt", 32'(frame_cnt), 3);

        // core flags an error on output beat 10
        start(64, 1'b0);
        stream(64, -1, 1'b0, xf, sop_at, eop_at, bad);
        drain(64, 10, dones, beats);
        chk("srcerr_err", 32'(err), 1);
        chk("srcerr_beats", 32'(beats), 11);
        chk("srcerr_no_done", 32'(dones), 0);
        chk("srcerr_frame_cnt", 32'(frame_cnt), 3);
        err_clear = 1'b1; step(); err_clear = 1'b0;

        // reset asserted mid-STREAM
        start(512, 1'b0);
        stream(512, 5, 1'b0, xf, sop_at, eop_at, bad);
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("pre_rst_sink_valid", 32'(sink_valid), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_sink_valid", 32'(sink_valid), 0);
        chk("async_rst_source_ready", 32'(source_ready), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_frame_cnt", 32'(frame_cnt), 0);
        in_valid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("post_rst_fftpts", 32'(fftpts_in), 1024);
        chk("post_rst_done", 32'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
